// File: rtl/multi_freq_meter_pkg.sv
// Shared types and helpers for the multi-channel frequency meter.
// Optional feature macro: FREQ_SCALE_EN (adds the SCALE state).
package multi_freq_meter_pkg;

  localparam int GATE_SEL_W = 2;

  localparam int unsigned DEC_X1    = 1;
  localparam int unsigned DEC_X10   = 10;
  localparam int unsigned DEC_X100  = 100;
  localparam int unsigned DEC_X1000 = 1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2,
    SCALE = 2'd3
  } state_t;

  // Window length in clock cycles; never returns 0 so the gate counter always runs.
  function automatic int unsigned gate_cycles(input int unsigned clk_hz,
                                              input logic [GATE_SEL_W-1:0] sel);
    int unsigned g;
    case (sel)
      2'd0:    g = clk_hz;
      2'd1:    g = clk_hz / DEC_X10;
      2'd2:    g = clk_hz / DEC_X100;
      default: g = clk_hz / DEC_X1000;
    endcase
    if (g == 0) g = 1;
    return g;
  endfunction

  // Multiplier that turns a window count into Hz for the given gate selection.
  function automatic int unsigned decade_mult(input logic [GATE_SEL_W-1:0] sel);
    int unsigned m;
    case (sel)
      2'd0:    m = DEC_X1;
      2'd1:    m = DEC_X10;
      2'd2:    m = DEC_X100;
      default: m = DEC_X1000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/freq_chan.sv
// One measurement channel: input synchroniser, rising-edge detector and a
// saturating edge counter with a sticky overflow bit.
// clear dominates load_one, which dominates count_en.
module freq_chan #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             sig_in,
  input  logic             clear,
  input  logic             load_one,
  input  logic             count_en,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   rise;

  // Next-state: shift synchroniser, detect rising edge, update counter
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load_one) begin
      // Window boundary: an edge arriving now belongs to the next window.
      cnt_d = CNT_W'(rise);
      ovf_d = 1'b0;
    end else if (count_en && rise) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/multi_freq_meter.sv
// N-channel frequency meter: gate timer, window FSM and result registers.
// Optional feature macro: FREQ_SCALE_EN reports count x 10^gate_sel in Hz
// through an extra SCALE cycle per window.
//
// state | meaning
// IDLE  | not measuring, channel counters held at 0, busy low
// COUNT | gate window open, channels count edges
// LATCH | window closed; counts captured, counters restart
// SCALE | captured counts multiplied to Hz (FREQ_SCALE_EN only)
module multi_freq_meter
  import multi_freq_meter_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = 24,
  parameter int CLK_HZ      = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    enable,
  input  logic [GATE_SEL_W-1:0]   gate_sel,
  input  logic [NUM_CH-1:0]       sig_in,
  output logic [NUM_CH*CNT_W-1:0] freq_out,
  output logic [NUM_CH-1:0]       ovf_out,
  output logic                    result_valid,
  output logic                    busy
);

  localparam int GATE_W = $clog2(CLK_HZ + 1);

  state_t                  state_q, state_d;
  logic [GATE_W-1:0]       gate_q, gate_d;
  logic [GATE_W-1:0]       gate_load;
  logic [NUM_CH*CNT_W-1:0] freq_q, freq_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d;
  logic                    valid_q, valid_d;
  logic [NUM_CH*CNT_W-1:0] cnt_flat;
  logic [NUM_CH-1:0]       ovf_flat;
  logic                    chan_clear, chan_load, chan_count;

`ifdef FREQ_SCALE_EN
  localparam int               PROD_W  = CNT_W + 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [GATE_SEL_W-1:0]   win_sel_q, win_sel_d;
  logic [NUM_CH*CNT_W-1:0] raw_q, raw_d;
  logic [NUM_CH-1:0]       raw_ovf_q, raw_ovf_d;
  logic [NUM_CH*CNT_W-1:0] scaled;
  logic [NUM_CH-1:0]       scaled_ovf;

  function automatic logic [CNT_W:0] scale_one(input logic [CNT_W-1:0]      raw,
                                               input logic [GATE_SEL_W-1:0] sel);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(raw) * PROD_W'(decade_mult(sel));
    if (prod > PROD_W'(CNT_MAX)) return {1'b1, CNT_MAX};
    return {1'b0, prod[CNT_W-1:0]};
  endfunction

  // Decade scaling of the captured counts, saturating into CNT_W bits
  always_comb begin
    scaled     = '0;
    scaled_ovf = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      {scaled_ovf[i], scaled[i*CNT_W +: CNT_W]} =
        scale_one(raw_q[i*CNT_W +: CNT_W], win_sel_q);
    end
  end
`endif

  // gate_sel only takes effect where a new window is loaded
  assign gate_load = GATE_W'(gate_cycles(CLK_HZ, gate_sel) - 1);

  // Window FSM: next state, gate timer, result capture and channel controls
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    chan_clear = 1'b0;
    chan_load  = 1'b0;
    chan_count = 1'b0;
`ifdef FREQ_SCALE_EN
    win_sel_d  = win_sel_q;
    raw_d      = raw_q;
    raw_ovf_d  = raw_ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        chan_clear = 1'b1;
        if (enable) begin
          state_d = COUNT;
          gate_d  = gate_load;
`ifdef FREQ_SCALE_EN
          win_sel_d = gate_sel;
`endif
        end
      end
      COUNT: begin
        chan_count = 1'b1;
        if (!enable)             state_d = IDLE;
        else if (gate_q == '0)   state_d = LATCH;
        else                     gate_d  = gate_q - GATE_W'(1);
      end
      LATCH: begin
        chan_load = 1'b1;
`ifdef FREQ_SCALE_EN
        raw_d     = cnt_flat;
        raw_ovf_d = ovf_flat;
        state_d   = SCALE;
`else
        freq_d  = cnt_flat;
        ovf_d   = ovf_flat;
        valid_d = 1'b1;
        if (enable) begin
          state_d = COUNT;
          gate_d  = gate_load;
        end else begin
          state_d = IDLE;
        end
`endif
      end
      SCALE: begin
`ifdef FREQ_SCALE_EN
        // Counters were restarted in LATCH, so this cycle already belongs to the next window.
        chan_count = 1'b1;
        freq_d     = scaled;
        ovf_d      = scaled_ovf | raw_ovf_q;
        valid_d    = 1'b1;
        if (enable) begin
          state_d   = COUNT;
          gate_d    = gate_load;
          win_sel_d = gate_sel;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers with synchronous active-low reset
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      freq_q    <= '0;
      ovf_q     <= '0;
      valid_q   <= 1'b0;
`ifdef FREQ_SCALE_EN
      win_sel_q <= '0;
      raw_q     <= '0;
      raw_ovf_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      freq_q    <= freq_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
`ifdef FREQ_SCALE_EN
      win_sel_q <= win_sel_d;
      raw_q     <= raw_d;
      raw_ovf_q <= raw_ovf_d;
`endif
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    freq_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .sig_in       (sig_in[i]),
      .clear        (chan_clear),
      .load_one     (chan_load),
      .count_en     (chan_count),
      .cnt          (cnt_flat[i*CNT_W +: CNT_W]),
      .ovf          (ovf_flat[i])
    );
  end

  assign freq_out     = freq_q;
  assign ovf_out      = ovf_q;
  assign result_valid = valid_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_multi_freq_meter.sv
// Directed bench for multi_freq_meter (NUM_CH=4, CNT_W=8, CLK_HZ=10_000).
// Cycle 0 is the IDLE cycle right after reset release with enable high;
// COUNT then occupies cycles 1..GATE. An input rising edge driven in cycle s
// reaches the counter logic in cycle s+2.
module tb_multi_freq_meter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
`ifdef FREQ_SCALE_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        enable;
  logic [1:0]  gate_sel;
  logic [3:0]  sig_in;
  logic [31:0] freq_out;
  logic [3:0]  ovf_out;
  logic        result_valid;
  logic        busy;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  always #5 clk_clk = ~clk_clk;

  multi_freq_meter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLK_HZ(10_000), .SYNC_STAGES(2)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .gate_sel(gate_sel), .sig_in(sig_in), .freq_out(freq_out),
    .ovf_out(ovf_out), .result_valid(result_valid), .busy(busy)
  );

  function automatic int mult_of(input int sel);
    if (S == 0) return 1;
    return (sel == 0) ? 1 : (sel == 1) ? 10 : (sel == 2) ? 100 : 1000;
  endfunction

  function automatic logic [7:0] exp_val(input int raw, input int sel);
    int v;
    v = ((raw > 255) ? 255 : raw) * mult_of(sel);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  function automatic logic exp_ovf(input int raw, input int sel);
    return (raw > 255) || (raw * mult_of(sel) > 255);
  endfunction

  function automatic logic [31:0] bus4(input logic [7:0] c0, input logic [7:0] c1,
                                       input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk_clk);
    #1;
    cyc++;
  endtask

  task automatic start(input logic [1:0] sel);
    reset_reset_n = 1'b0;
    enable        = 1'b0;
    sig_in        = '0;
    gate_sel      = sel;
    tick();
    tick();
    reset_reset_n = 1'b1;
    enable        = 1'b1;
    cyc           = 0;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    enable        = 1'b0;
    gate_sel      = 2'd0;
    sig_in        = '0;
    tick();
    tick();
    checks++; if (freq_out !== 32'h0) $display("FAIL reset_freq: got %h expected 0", freq_out); else passed++;
    checks++; if (ovf_out !== 4'h0) $display("FAIL reset_ovf: got %b expected 0", ovf_out); else passed++;
    checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", result_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_basic();
    int          rv_cyc[2];
    logic [31:0] rv_freq[2];
    logic [3:0]  rv_ovf[2];
    int          n = 0;
    rv_cyc = '{0, 0}; rv_freq = '{0, 0}; rv_ovf = '{0, 0};
    start(2'd3);
    for (int k = 0; k < 30; k++) begin
      tick();
      sig_in[0] = (((cyc - 1) / 2) % 2) == 0;
      if (result_valid && n < 2) begin
        rv_cyc[n] = cyc; rv_freq[n] = freq_out; rv_ovf[n] = ovf_out; n++;
      end
    end
    checks++; if (n != 2) $display("FAIL basic_nvalid: got %0d expected 2", n); else passed++;
    checks++; if (rv_cyc[0] != 12 + S) $display("FAIL basic_first_valid: got cycle %0d expected %0d", rv_cyc[0], 12 + S); else passed++;
    checks++; if (rv_cyc[1] - rv_cyc[0] != 11 + S) $display("FAIL basic_period: got %0d expected %0d", rv_cyc[1] - rv_cyc[0], 11 + S); else passed++;
    checks++; if (rv_freq[0] !== bus4(exp_val(2, 3), 0, 0, 0)) $display("FAIL basic_w1_freq: got %h expected %h", rv_freq[0], bus4(exp_val(2, 3), 0, 0, 0)); else passed++;
    checks++; if (rv_ovf[0] !== {3'b0, exp_ovf(2, 3)}) $display("FAIL basic_w1_ovf: got %b expected %b", rv_ovf[0], {3'b0, exp_ovf(2, 3)}); else passed++;
    checks++; if (rv_freq[1] !== bus4(exp_val(3, 3), 0, 0, 0)) $display("FAIL basic_w2_freq: got %h expected %h", rv_freq[1], bus4(exp_val(3, 3), 0, 0, 0)); else passed++;
    checks++; if (rv_ovf[1] !== {3'b0, exp_ovf(3, 3)}) $display("FAIL basic_w2_ovf: got %b expected %b", rv_ovf[1], {3'b0, exp_ovf(3, 3)}); else passed++;
  endtask

  task automatic test_gate0();
    logic [31:0] rv_freq[3];
    logic [3:0]  rv_ovf[3];
    int          n = 0;
    rv_freq = '{0, 0, 0}; rv_ovf = '{0, 0, 0};
    start(2'd0);
    for (int k = 0; k < 30010; k++) begin
      tick();
      if (cyc <= 9990)                      sig_in[1] = ((cyc - 1) % 40) < 20;
      else if (cyc >= 10100 && cyc < 15000) sig_in[1] = ((cyc - 10100) % 10) < 5;
      else                                  sig_in[1] = 1'b0;
      if (result_valid && n < 3) begin
        rv_freq[n] = freq_out; rv_ovf[n] = ovf_out; n++;
      end
    end
    checks++; if (n != 3) $display("FAIL gate0_nvalid: got %0d expected 3", n); else passed++;
    checks++; if (rv_freq[0] !== bus4(0, exp_val(250, 0), 0, 0)) $display("FAIL gate0_250_freq: got %h expected %h", rv_freq[0], bus4(0, exp_val(250, 0), 0, 0)); else passed++;
    checks++; if (rv_ovf[0] !== 4'b0000) $display("FAIL gate0_250_ovf: got %b expected 0000", rv_ovf[0]); else passed++;
    checks++; if (rv_freq[1] !== bus4(0, 8'd255, 0, 0)) $display("FAIL gate0_sat_freq: got %h expected %h", rv_freq[1], bus4(0, 8'd255, 0, 0)); else passed++;
    checks++; if (rv_ovf[1] !== 4'b0010) $display("FAIL gate0_sat_ovf: got %b expected 0010", rv_ovf[1]); else passed++;
    checks++; if (rv_freq[2] !== 32'h0) $display("FAIL gate0_idle_freq: got %h expected 0", rv_freq[2]); else passed++;
    checks++; if (rv_ovf[2] !== 4'b0000) $display("FAIL gate0_idle_ovf: got %b expected 0000", rv_ovf[2]); else passed++;
  endtask

  task automatic test_boundary();
    logic [31:0] rv_freq[2];
    logic [3:0]  rv_ovf[2];
    int          n = 0;
    rv_freq = '{0, 0}; rv_ovf = '{0, 0};
    start(2'd3);
    for (int k = 0; k < 30; k++) begin
      tick();
      sig_in[0] = (cyc == 8);
      sig_in[2] = (cyc == 9);
      if (result_valid && n < 2) begin
        rv_freq[n] = freq_out; rv_ovf[n] = ovf_out; n++;
      end
    end
    checks++; if (rv_freq[0] !== bus4(exp_val(1, 3), 0, 0, 0)) $display("FAIL edge_last_count: got %h expected %h", rv_freq[0], bus4(exp_val(1, 3), 0, 0, 0)); else passed++;
    checks++; if (rv_ovf[0] !== {3'b0, exp_ovf(1, 3)}) $display("FAIL edge_last_count_ovf: got %b expected %b", rv_ovf[0], {3'b0, exp_ovf(1, 3)}); else passed++;
    checks++; if (rv_freq[1] !== bus4(0, 0, exp_val(1, 3), 0)) $display("FAIL edge_latch_cycle: got %h expected %h", rv_freq[1], bus4(0, 0, exp_val(1, 3), 0)); else passed++;
    checks++; if (rv_ovf[1] !== {1'b0, exp_ovf(1, 3), 2'b0}) $display("FAIL edge_latch_cycle_ovf: got %b expected %b", rv_ovf[1], {1'b0, exp_ovf(1, 3), 2'b0}); else passed++;
  endtask

  task automatic test_gate_change();
    int rv_cyc[2];
    int n = 0;
    rv_cyc = '{0, 0};
    start(2'd3);
    for (int k = 0; k < 130; k++) begin
      tick();
      if (cyc == 5) gate_sel = 2'd2;
      if (result_valid && n < 2) begin
        rv_cyc[n] = cyc; n++;
      end
    end
    checks++; if (rv_cyc[0] != 12 + S) $display("FAIL gsel_current_window: got cycle %0d expected %0d", rv_cyc[0], 12 + S); else passed++;
    checks++; if (rv_cyc[1] - rv_cyc[0] != 101 + S) $display("FAIL gsel_next_window: got %0d expected %0d", rv_cyc[1] - rv_cyc[0], 101 + S); else passed++;
  endtask

  task automatic test_abort();
    int          first_rv = 0;
    int          stray_rv = 0;
    int          re_rv    = 0;
    logic [31:0] re_freq  = '1;
    logic [31:0] held     = '0;
    start(2'd3);
    for (int k = 0; k < 60; k++) begin
      tick();
      sig_in[0] = (cyc == 2) || (cyc == 13 + S);
      if (cyc == 16 + S) begin
        checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy); else passed++;
        enable = 1'b0;
      end
      if (cyc == 17 + S) begin
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy_after: got %b expected 0", busy); else passed++;
      end
      if (cyc == 29) held = freq_out;
      if (cyc == 30) enable = 1'b1;
      if (result_valid) begin
        if (cyc <= 12 + S && first_rv == 0) first_rv = cyc;
        else if (cyc < 42 + S) stray_rv++;
        else if (re_rv == 0) begin re_rv = cyc; re_freq = freq_out; end
      end
    end
    checks++; if (first_rv != 12 + S) $display("FAIL abort_first_valid: got cycle %0d expected %0d", first_rv, 12 + S); else passed++;
    checks++; if (stray_rv != 0) $display("FAIL abort_no_valid: got %0d pulses expected 0", stray_rv); else passed++;
    checks++; if (held !== bus4(exp_val(1, 3), 0, 0, 0)) $display("FAIL abort_freq_held: got %h expected %h", held, bus4(exp_val(1, 3), 0, 0, 0)); else passed++;
    checks++; if (re_rv != 42 + S) $display("FAIL abort_restart_valid: got cycle %0d expected %0d", re_rv, 42 + S); else passed++;
    checks++; if (re_freq !== 32'h0) $display("FAIL abort_restart_freq: got %h expected 0", re_freq); else passed++;
  endtask

  task automatic test_mid_reset();
    int          d        = 17 + S;
    int          pre_rv   = 0;
    int          stray_rv = 0;
    int          post_rv  = 0;
    logic [31:0] pre_freq  = '0;
    logic [31:0] post_freq = '1;
    start(2'd3);
    for (int k = 0; k < 50; k++) begin
      tick();
      sig_in[0] = (cyc == 2) || (cyc == d + 2);
      sig_in[1] = (cyc == 14 + S);
      if (cyc == d + 1) begin
        checks++; if (freq_out !== 32'h0) $display("FAIL mreset_freq: got %h expected 0", freq_out); else passed++;
        checks++; if (ovf_out !== 4'h0) $display("FAIL mreset_ovf: got %b expected 0", ovf_out); else passed++;
        checks++; if (result_valid !== 1'b0) $display("FAIL mreset_valid: got %b expected 0", result_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mreset_busy: got %b expected 0", busy); else passed++;
        reset_reset_n = 1'b1;
      end
      if (cyc == d) reset_reset_n = 1'b0;
      if (result_valid) begin
        if (cyc <= 12 + S && pre_rv == 0) begin pre_rv = cyc; pre_freq = freq_out; end
        else if (cyc < 30 + 2 * S) stray_rv++;
        else if (post_rv == 0) begin post_rv = cyc; post_freq = freq_out; end
      end
    end
    checks++; if (pre_freq !== bus4(exp_val(1, 3), 0, 0, 0)) $display("FAIL mreset_pre_result: got %h expected %h", pre_freq, bus4(exp_val(1, 3), 0, 0, 0)); else passed++;
    checks++; if (stray_rv != 0) $display("FAIL mreset_no_valid: got %0d pulses expected 0", stray_rv); else passed++;
    checks++; if (post_rv != 30 + 2 * S) $display("FAIL mreset_post_valid: got cycle %0d expected %0d", post_rv, 30 + 2 * S); else passed++;
    checks++; if (post_freq !== bus4(exp_val(1, 3), 0, 0, 0)) $display("FAIL mreset_post_result: got %h expected %h", post_freq, bus4(exp_val(1, 3), 0, 0, 0)); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gate0();
    test_boundary();
    test_gate_change();
    test_abort();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
